hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It shadows destination-register state for the EX, MEM and WB stages and compares it with the source registers of the instruction in ID. From that it drives PC/IF-ID stall, the ID-EX bubble, branch flush and the registered EX-stage forwarding selects. It sits beside the decode stage and immediate generator and sequences the whole datapath.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/inst_regs_dec.sv | 44 ++++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the decode stage, the immediate generator
// and the hazard controller.
//   - OP_*          : major opcode values (inst[6:0])
//   - fwd_sel_e     : EX operand source select
//   - stage_info_t  : per-stage destination shadow {valid, rd, regwrite, memread}
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } stage_info_t;

    localparam stage_info_t STAGE_NONE = '0;

endpackage

// File: rtl/inst_regs_dec.sv
// Register-usage decoder for the instruction sitting in IF/ID.
// Purely combinational.
//   inst      in  32  raw instruction
//   rs1/rs2   out 5   source register fields
//   rd        out 5   destination register field
//   use_rs1   out 1   rs1 is read and is not x0
//   use_rs2   out 1   rs2 is read and is not x0
//   regwrite  out 1   instruction writes a register other than x0
//   memread   out 1   instruction is a load
module inst_regs_dec
    import riscv_pkg::*;
(
    input  logic [31:0] inst,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        use_rs1,
    output logic        use_rs2,
    output logic        regwrite,
    output logic        memread
);

    logic [6:0] opcode;
    // funct3/funct7 do not affect register usage
    logic       unused_fields;

    assign opcode        = inst[6:0];
    assign rs1           = inst[19:15];
    assign rs2           = inst[24:20];
    assign rd            = inst[11:7];
    assign unused_fields = ^{inst[31:25], inst[14:12]};

    // x0 is folded in here so the hazard comparators never see it:
    // a read of x0 never matches and a write to x0 is never a write.
    always_comb begin
        use_rs1  = (opcode inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR})
                   && (rs1 != 5'd0);
        use_rs2  = (opcode inside {OP_R, OP_STORE, OP_BRANCH}) && (rs2 != 5'd0);
        regwrite = (opcode inside {OP_R, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR})
                   && (rd != 5'd0);
        memread  = (opcode == OP_LOAD);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core.
// Shadows the destination state of EX/MEM/WB and compares it with the sources
// of the instruction in ID to produce stall, ID/EX bubble, branch flush and
// registered EX forwarding selects.
//
// Build option: FORWARD_EN
//   defined   : EX/MEM and MEM/WB forwarding; only load-use stalls (1 cycle).
//   undefined : no forwarding (fwd_* = 00); stall on any EX or MEM match.
//
// Ports:
//   clk              in  1      core clock, rising edge
//   rst              in  1      async active-high reset
//   id_inst          in  32     instruction in IF/ID
//   id_valid         in  1      IF/ID holds a real instruction
//   ex_branch_taken  in  1      control transfer in EX redirects PC
//   stall            out 1      hold PC and IF/ID
//   flush_id         out 1      invalidate IF/ID on next edge
//   bubble_ex        out 1      load NOP into ID/EX on next edge
//   fwd_a / fwd_b    out 2      EX operand selects (00 RF, 01 EX/MEM, 10 MEM/WB)
//   stall_cnt        out CNT_W  saturating count of stalled cycles
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_inst,
    input  logic             id_valid,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_regwrite, id_memread;

    stage_info_t ex_p1, mem_p2, wb_p3;
    logic        ex_hit, mem_hit, stall_raw, advance;
    logic [CNT_W-1:0] stall_cnt_q;

    function automatic logic hit(input stage_info_t s, input logic [4:0] rs,
                                 input logic use_rs);
        return use_rs && s.valid && s.regwrite && (s.rd == rs);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    inst_regs_dec u_dec (
        .inst     (id_inst),
        .rs1      (id_rs1),
        .rs2      (id_rs2),
        .rd       (id_rd),
        .use_rs1  (id_use_rs1),
        .use_rs2  (id_use_rs2),
        .regwrite (id_regwrite),
        .memread  (id_memread)
    );

    assign ex_hit  = hit(ex_p1, id_rs1, id_use_rs1) | hit(ex_p1, id_rs2, id_use_rs2);
    assign mem_hit = hit(mem_p2, id_rs1, id_use_rs1) | hit(mem_p2, id_rs2, id_use_rs2);

`ifdef FORWARD_EN
    assign stall_raw = ex_hit & ex_p1.memread;
`else
    assign stall_raw = ex_hit | mem_hit;
`endif

    // A taken branch discards the ID instruction, so it overrides any stall.
    assign stall     = id_valid & stall_raw & ~ex_branch_taken;
    assign bubble_ex = stall | ex_branch_taken;
    assign flush_id  = ex_branch_taken;
    assign advance   = id_valid & ~stall & ~ex_branch_taken;
    assign stall_cnt = stall_cnt_q;

    // ---- ID -> EX -> MEM -> WB shadow pipeline ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_p1  <= STAGE_NONE;
            mem_p2 <= STAGE_NONE;
            wb_p3  <= STAGE_NONE;
        end else begin
            wb_p3  <= mem_p2;
            mem_p2 <= ex_p1;
            ex_p1  <= advance ? {1'b1, id_rd, id_regwrite, id_memread} : STAGE_NONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

`ifdef FORWARD_EN
    fwd_sel_e fwd_a_p1, fwd_b_p1;

    // Nearest producer wins: EX/MEM is younger than MEM/WB.
    function automatic fwd_sel_e fwd_pick(input logic [4:0] rs, input logic use_rs);
        if (hit(ex_p1, rs, use_rs)) begin
            return FWD_EXMEM;
        end else if (hit(mem_p2, rs, use_rs)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

    // ---- ID -> EX forwarding select ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_p1 <= FWD_RF;
            fwd_b_p1 <= FWD_RF;
        end else if (advance) begin
            fwd_a_p1 <= fwd_pick(id_rs1, id_use_rs1);
            fwd_b_p1 <= fwd_pick(id_rs2, id_use_rs2);
        end else begin
            fwd_a_p1 <= FWD_RF;
            fwd_b_p1 <= FWD_RF;
        end
    end

    assign fwd_a = fwd_a_p1;
    assign fwd_b = fwd_b_p1;

    // Regfile is write-through, so the WB shadow and MEM load flag have no reader.
    logic unused_shadow;
    assign unused_shadow = ^{wb_p3, mem_p2.memread};
`else
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;

    // Without forwarding the load flag is irrelevant; WB is never a hazard source.
    logic unused_shadow;
    assign unused_shadow = ^{wb_p3, mem_p2.memread, ex_p1.memread};
`endif

endmodule
